// File: rtl/move_scheduler_pkg.sv
// Shared piece types, coordinate widths, piece indices, scheduler states and the wall-kick table.
// WALL_KICK_EN adds the KICK state and enables kick retries of rejected rotations.
package move_scheduler_pkg;

  localparam int X_W    = 5;
  localparam int Y_W    = 5;
  localparam int IDX_W  = 3;
  localparam int DATA_W = 16;

  localparam logic [IDX_W-1:0] PIECE_I = 3'd0;
  localparam logic [IDX_W-1:0] PIECE_O = 3'd1;
  localparam logic [IDX_W-1:0] PIECE_T = 3'd2;
  localparam logic [IDX_W-1:0] PIECE_S = 3'd3;
  localparam logic [IDX_W-1:0] PIECE_Z = 3'd4;
  localparam logic [IDX_W-1:0] PIECE_J = 3'd5;
  localparam logic [IDX_W-1:0] PIECE_L = 3'd6;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [1:0]        rotation;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [DATA_W-1:0] data;
  } tetromino_ctrl;

  // Enum value doubles as the pending-bit index.
  typedef enum logic [1:0] {MV_DOWN, MV_ROT, MV_LEFT, MV_RIGHT} move_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_COMMIT, S_REJECT
`ifdef WALL_KICK_EN
    , S_KICK
`endif
  } state_t;

  // Kick sequence: +0, -1, +1, then -2, +2 for the I-piece only.
  function automatic logic [X_W-1:0] kick_ofs(input logic [2:0] k);
    case (k)
      3'd1:    kick_ofs = X_W'(-1);
      3'd2:    kick_ofs = X_W'(1);
      3'd3:    kick_ofs = X_W'(-2);
      3'd4:    kick_ofs = X_W'(2);
      default: kick_ofs = '0;
    endcase
  endfunction

  function automatic logic [2:0] kick_cnt(input logic [IDX_W-1:0] idx);
    kick_cnt = (idx == PIECE_I) ? 3'd5 : 3'd3;
  endfunction

endpackage

// File: rtl/move_scheduler_candidate.sv
// Combinational candidate builder: applies one move (plus kick offset for rotation) to a piece.
// Kick index is only ever non-zero when WALL_KICK_EN is defined.
module move_candidate
  import move_scheduler_pkg::*;
(
  input  move_t         mv,
  input  logic [2:0]    kick,
  input  tetromino_ctrl t,
  output tetromino_ctrl c
);

  always_comb begin
    c = t;
    unique case (mv)
      MV_DOWN:  c.y = t.y + Y_W'(1);
      MV_LEFT:  c.x = t.x - X_W'(1);
      MV_RIGHT: c.x = t.x + X_W'(1);
      MV_ROT: begin
        c.rotation = t.rotation + 2'd1;
        c.x        = t.x + kick_ofs(kick);
      end
      default: c = t;
    endcase
  end

endmodule

// File: rtl/move_scheduler.sv
// Arbitrates move requests onto a shared collision checker and commits accepted pieces.
// WALL_KICK_EN: rejected rotations retry with x offsets from the kick table.
module move_scheduler
  import move_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_down,
  input  logic          req_rotate,
  input  logic          req_left,
  input  logic          req_right,
  input  tetromino_ctrl t_cur,
  output logic          check_valid,
  output tetromino_ctrl check_t,
  input  logic          check_done,
  input  logic          check_ok,
  output logic          commit,
  output tetromino_ctrl t_next,
  output logic          landed,
  output logic          busy,
  output logic          timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_t        state, state_n;
  logic [3:0]    pend_q, clr, req_vec;
  move_t         mv_q, g_mv, bld_mv;
  logic          grant, to_fire, timeout_q;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    bld_kick;
  tetromino_ctrl cand_q, t_next_q, bld_t, cand;

  assign req_vec = {req_right, req_left, req_rotate, req_down};

`ifdef WALL_KICK_EN
  logic [2:0]    kick_q;
  tetromino_ctrl base_q;
  assign bld_t    = (state == S_KICK) ? base_q : t_cur;
  assign bld_mv   = (state == S_KICK) ? mv_q : g_mv;
  assign bld_kick = (state == S_KICK) ? kick_q + 3'd1 : 3'd0;
`else
  assign bld_t    = t_cur;
  assign bld_mv   = g_mv;
  assign bld_kick = 3'd0;
`endif

  move_candidate u_cand (.mv(bld_mv), .kick(bld_kick), .t(bld_t), .c(cand));

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    g_mv    = MV_DOWN;
    clr     = '0;
    to_fire = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_q[MV_DOWN]) begin
          grant = 1'b1; g_mv = MV_DOWN;
        end else if (pend_q[MV_ROT]) begin
          grant = 1'b1; g_mv = MV_ROT;
        end else if (pend_q[MV_LEFT] && pend_q[MV_RIGHT]) begin
          // Opposing sideways requests cancel without touching the checker.
          clr[MV_LEFT]  = 1'b1;
          clr[MV_RIGHT] = 1'b1;
        end else if (pend_q[MV_LEFT]) begin
          grant = 1'b1; g_mv = MV_LEFT;
        end else if (pend_q[MV_RIGHT]) begin
          grant = 1'b1; g_mv = MV_RIGHT;
        end
        if (grant) state_n = S_ISSUE;
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (check_done) begin
          if (check_ok) begin
            state_n    = S_COMMIT;
            clr[mv_q]  = 1'b1;
          end else begin
`ifdef WALL_KICK_EN
            if (mv_q == MV_ROT && (kick_q + 3'd1) < kick_cnt(base_q.idx)) begin
              state_n = S_KICK;
            end else begin
              state_n   = S_REJECT;
              clr[mv_q] = 1'b1;
            end
`else
            state_n   = S_REJECT;
            clr[mv_q] = 1'b1;
`endif
          end
        end else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
          state_n   = S_IDLE;
          clr[mv_q] = 1'b1;
          to_fire   = 1'b1;
        end
      end
`ifdef WALL_KICK_EN
      S_KICK: state_n = S_ISSUE;
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pend_q    <= '0;
      mv_q      <= MV_DOWN;
      wait_cnt  <= '0;
      cand_q    <= '0;
      t_next_q  <= '0;
      timeout_q <= 1'b0;
`ifdef WALL_KICK_EN
      kick_q    <= '0;
      base_q    <= '0;
`endif
    end else begin
      state     <= state_n;
      // New pulses win over a same-cycle clear so no request is lost.
      pend_q    <= (pend_q & ~clr) | req_vec;
      timeout_q <= to_fire;
      wait_cnt  <= (state == S_WAIT) ? wait_cnt + CW'(1) : '0;
      if (grant) begin
        mv_q   <= g_mv;
        cand_q <= cand;
`ifdef WALL_KICK_EN
        kick_q <= '0;
        base_q <= t_cur;
`endif
      end
`ifdef WALL_KICK_EN
      if (state == S_KICK) begin
        kick_q <= kick_q + 3'd1;
        cand_q <= cand;
      end
`endif
      if (state == S_WAIT && check_done && check_ok) t_next_q <= cand_q;
    end
  end

  assign busy        = (state != S_IDLE);
  assign check_valid = (state == S_ISSUE);
  assign check_t     = cand_q;
  assign commit      = (state == S_COMMIT);
  assign landed      = (state == S_REJECT) && (mv_q == MV_DOWN);
  assign t_next      = t_next_q;
  assign timeout_err = timeout_q;

endmodule
